// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: word/address widths, the fetch unit
// state encoding, the default reset PC and instruction field positions.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  // Instruction fields shared between ifu and cu
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } ifu_state_t;

  function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [3:0] funct_of(input logic [WORD_W-1:0] word);
    return word[FN_HI:FN_LO];
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word at a time over a req/ack handshake,
// holds it for cu, follows branch redirects and stops after a halt decode.
module ifu
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] code,
  output logic [ADDR_W-1:0] code_pc,
  output logic              code_valid,
  input  logic              code_ready,
  input  logic              stahp,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  ifu_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic              discard;

  // A request in flight is never aborted; a redirect during FETCH only marks
  // the pending response for discard and retargets pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      code       <= '0;
      code_pc    <= '0;
      code_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_FETCH;
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end

        ST_FETCH: begin
          if (mem_ack) begin
            if (discard || redirect) begin
              discard <= 1'b0;
              if (redirect) begin
                pc       <= redirect_pc;
                mem_addr <= redirect_pc;
              end else begin
                mem_addr <= pc;
              end
            end else begin
              code       <= mem_rdata;
              code_pc    <= mem_addr;
              pc         <= mem_addr + 16'd1;
              code_valid <= 1'b1;
              mem_req    <= 1'b0;
              state      <= ST_HOLD;
            end
          end else if (redirect) begin
            discard <= 1'b1;
            pc      <= redirect_pc;
          end
        end

        // Redirect beats both stahp and sequential fetch, accepted or not
        ST_HOLD: begin
          if (redirect) begin
            code_valid <= 1'b0;
            pc         <= redirect_pc;
            mem_req    <= 1'b1;
            mem_addr   <= redirect_pc;
            state      <= ST_FETCH;
          end else if (code_ready) begin
            code_valid <= 1'b0;
            if (stahp) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= ST_FETCH;
            end
          end
        end

        ST_HALT: begin
        end

        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the 16-bit CPU. It reads instruction words from instruction memory over a req/ack handshake and holds each word in an instruction register. It presents the word as `code` to the control unit `cu` with a valid/ready handshake. It also applies branch redirects from execute and stops fetching once `cu` asserts `stahp` on an accepted instruction.

## Interface
- `RESET_PC`, 16'h0000, word address fetched first after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_req`  out  1  fetch request; held until `mem_ack`
- `mem_addr`  out  16  word address of the current request; stable while `mem_req`=1
- `mem_ack`  in  1  memory response; may arrive the same cycle `mem_req` rises
- `mem_rdata`  in  16  instruction word; valid only when `mem_ack`=1
- `code`  out  16  instruction to `cu` (opcode [15:12], function code [3:0])
- `code_pc`  out  16  word address of `code`
- `code_valid`  out  1  `code` holds a valid instruction
- `code_ready`  in  1  execute/cu accepts `code` this cycle
- `stahp`  in  1  halt decode from `cu`, sampled on accept
- `redirect`  in  1  branch/jump taken, single-cycle pulse
- `redirect_pc`  in  16  new fetch address; valid with `redirect`
- `halted`  out  1  fetch has stopped

## Operation
- States:
  - RESET: entered on `rst`
  - FETCH: `mem_req`=1
  - HOLD: `code_valid`=1
  - HALT
- Internal registers: `pc` (next fetch address) and `discard` flag.
- RESET -> FETCH in the first cycle after `rst` falls.
- FETCH:
  - `mem_addr` is registered from `pc` on entry.
  - On `mem_ack` with `discard`=0, load `code`<=`mem_rdata`, `code_pc`<=`mem_addr`, `pc`<=`mem_addr`+1, go to HOLD.
- HOLD:
  - On `code_valid & code_ready & ~stahp`, go to FETCH at `pc`.
  - On `code_valid & code_ready & stahp`, go to HALT.
  - Otherwise hold `code` and `code_pc` unchanged.
- HALT:
  - `mem_req`=0, `code_valid`=0, `halted`=1.
  - `redirect` is ignored.
  - Only `rst` exits HALT.
- Redirect in HOLD: drop `code_valid` next cycle, `pc`<=`redirect_pc`, go to FETCH. If an accept occurs the same cycle, the accept is honoured (it is the branch itself), `redirect` wins over both `stahp` and sequential fetch.
- Redirect in FETCH:
  - The handshake is never aborted: `mem_req` and `mem_addr` stay unchanged until `mem_ack`.
  - Set `discard`=1 and `pc`<=`redirect_pc`.
  - On `mem_ack` with `discard`=1, drop the data, clear `discard`, and re-enter FETCH at `pc`.
  - A redirect in the same cycle as `mem_ack` also discards that response.
  - A second redirect while `discard`=1 overwrites `pc`.
- Priority: `rst` > `redirect` > `stahp` > normal flow.
- Arithmetic: `pc` increment is modulo 2^16 (16'hFFFF -> 16'h0000). No other arithmetic.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `code`=16'h0000, `code_pc`=16'h0000, `code_valid`=0, `halted`=0, `discard`=0, `pc`=`RESET_PC`.
- Cycle 0 is the first cycle with `rst`=0. `mem_req`=1 in cycle 1 with `mem_addr`=`RESET_PC`.
- Ack in cycle t -> `code_valid`=1 in cycle t+1.
- Accept in cycle t -> `mem_req`=1 in cycle t+1.
- No prefetch: with zero-wait memory and `code_ready` tied high, one instruction issues every 2 cycles.
- Redirect in HOLD at cycle t -> `code_valid`=0 and `mem_req`=1 with `mem_addr`=`redirect_pc` at t+1.
- Discarded ack at cycle t -> new request at t+1.
- `stahp` accept at cycle t -> `halted`=1 and `code_valid`=0 at t+1; `mem_req` stays 0 thereafter.
- `rst` mid-handshake: all state returns to reset values next cycle. No ack bookkeeping survives reset; the memory model must tolerate the abandoned request.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `cpu_pkg` holds:
  - the 16-bit word and address width constants
  - the `ifu` state encoding (RESET, FETCH, HOLD, HALT)
  - the default `RESET_PC`
  - opcode field positions [15:12] and [3:0], shared with `cu`
- Single module. No sub-module: the one-entry instruction register stays inline.

## Test plan
- Reset release, ack on the same cycle as req, `mem_rdata`=16'hF001, `code_ready`=1 -> `mem_addr`=0000 in cycle 1; `code`=F001, `code_pc`=0000, `code_valid`=1 in cycle 2; next request at `mem_addr`=0001 in cycle 3.
- Ack delayed 3 cycles, then `code_ready` held low 4 cycles -> `mem_addr` stable during the wait; `code`/`code_pc` stable while unaccepted; exactly one fetch per instruction.
- `redirect`=1 with `redirect_pc`=0040 while FETCH of address 0005 is waiting on ack -> `mem_addr` stays 0005 until ack; data discarded; next request at 0040; no `code_valid` for 0005.
- Accept of `code`=F008 with `stahp`=1 -> `halted`=1 next cycle; `mem_req`=0 for 20 cycles; `redirect` ignored; `rst` restarts at `RESET_PC`.
- `pc` wrap: redirect to FFFF, ack and accept -> next `mem_addr`=0000.
- `rst` asserted while `mem_req`=1 and `code_valid`=1 -> all outputs at reset values next cycle; fetch resumes at `RESET_PC`.
